// File: rtl/ariane_pkg.sv
// -----------------------------------------------------------------------------
// ariane_pkg
//   Shared D-cache definitions used by the flush responder.
//   - Default D-cache geometry (associativity, index/offset/tag widths).
//   - flush_state_e : state encoding of the flush FSM.
//   - flush_wb_req_t: packed write-back request (addr, idx, way) laid out for
//                     the default geometry.
// -----------------------------------------------------------------------------
package ariane_pkg;

    localparam int unsigned DCACHE_SET_ASSOC    = 8;
    // Index width counts the byte offset as well: set index + line offset.
    localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
    localparam int unsigned DCACHE_TAG_WIDTH    = 44;
    localparam int unsigned DCACHE_NUM_SETS     =
        2 ** (DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_TAG   = 3'd1,
        CHECK    = 3'd2,
        WB_REQ   = 3'd3,
        WB_WAIT  = 3'd4,
        INVAL    = 3'd5,
        ACK      = 3'd6,
        WAIT_LOW = 3'd7
    } flush_state_e;

    typedef struct packed {
        logic [DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH-1:0]         addr;
        logic [DCACHE_INDEX_WIDTH-DCACHE_OFFSET_WIDTH-1:0]      idx;
        logic [$clog2(DCACHE_SET_ASSOC)-1:0]                    way;
    } flush_wb_req_t;

endpackage

// File: rtl/dcache_flush_unit_walker.sv
// -----------------------------------------------------------------------------
// dcache_flush_walker
//   Set/way counter pair that walks the whole tag array during a flush.
//   Way is the inner loop; index advances when way wraps to 0.
//   NUM_WAYS must be at least 2.
//
// Ports
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : synchronous clear (same effect as reset)
//   start_i      : restart the walk at set 0 / way 0
//   adv_i        : step to the next line
//   idx_o, way_o : current set / way
//   last_o       : current line is the final set / final way
// -----------------------------------------------------------------------------
module dcache_flush_walker #(
    parameter int unsigned NUM_SETS = 256,
    parameter int unsigned NUM_WAYS = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic                        start_i,
    input  logic                        adv_i,
    output logic [$clog2(NUM_SETS)-1:0] idx_o,
    output logic [$clog2(NUM_WAYS)-1:0] way_o,
    output logic                        last_o
);

    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned WAY_W = $clog2(NUM_WAYS);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WAY_W-1:0] way_q, way_d;
    logic             idx_last, way_last;

    assign idx_last = (idx_q == IDX_W'(NUM_SETS - 1));
    assign way_last = (way_q == WAY_W'(NUM_WAYS - 1));

    always_comb begin
        idx_d = idx_q;
        way_d = way_q;
        if (clr_i || start_i) begin
            idx_d = '0;
            way_d = '0;
        end else if (adv_i) begin
            if (way_last) begin
                way_d = '0;
                idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
            end else begin
                way_d = way_q + WAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= '0;
            way_q <= '0;
        end else begin
            idx_q <= idx_d;
            way_q <= way_d;
        end
    end

    assign idx_o  = idx_q;
    assign way_o  = way_q;
    assign last_o = idx_last && way_last;

endmodule

// File: rtl/dcache_flush_unit.sv
// -----------------------------------------------------------------------------
// dcache_flush_unit
//   Responder side of the D-cache flush handshake. On a level flush request it
//   reads every set/way of the tag array, writes back dirty lines, invalidates
//   every line, then pulses flush_ack_o for one cycle and waits for the request
//   to drop before going idle again.
//
// Ports
//   clk_i, rst_i, clr_i      : clock, async active-high reset, sync clear
//   flush_i / flush_ack_o    : flush request (level) / completion pulse
//   busy_o                   : any state other than IDLE
//   arr_req_o/arr_gnt_i/arr_we_o/arr_idx_o/arr_way_o : tag-array access
//   arr_valid_i/arr_dirty_i/arr_tag_i : read data, one cycle after read grant
//   wb_req_o/wb_addr_o/wb_idx_o/wb_way_o/wb_gnt_i/wb_done_i : write-back path
//   wb_count_o               : dirty lines written back by the last flush
//
// Build option
//   DCACHE_FLUSH_STATS_EN : when defined, wb_count_o is a 32-bit saturating
//   count of completed write-backs; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module dcache_flush_unit
    import ariane_pkg::*;
#(
    parameter int unsigned NUM_SETS    = DCACHE_NUM_SETS,
    parameter int unsigned NUM_WAYS    = DCACHE_SET_ASSOC,
    parameter int unsigned TAG_W       = DCACHE_TAG_WIDTH,
    parameter int unsigned LINE_OFFSET = DCACHE_OFFSET_WIDTH,
    parameter int unsigned ADDR_W      = TAG_W + $clog2(NUM_SETS) + LINE_OFFSET
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic                        flush_i,
    output logic                        flush_ack_o,
    output logic                        busy_o,
    output logic                        arr_req_o,
    input  logic                        arr_gnt_i,
    output logic                        arr_we_o,
    output logic [$clog2(NUM_SETS)-1:0] arr_idx_o,
    output logic [$clog2(NUM_WAYS)-1:0] arr_way_o,
    input  logic                        arr_valid_i,
    input  logic                        arr_dirty_i,
    input  logic [TAG_W-1:0]            arr_tag_i,
    output logic                        wb_req_o,
    output logic [ADDR_W-1:0]           wb_addr_o,
    output logic [$clog2(NUM_SETS)-1:0] wb_idx_o,
    output logic [$clog2(NUM_WAYS)-1:0] wb_way_o,
    input  logic                        wb_gnt_i,
    input  logic                        wb_done_i,
    output logic [31:0]                 wb_count_o
);

    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned WAY_W = $clog2(NUM_WAYS);

    flush_state_e     state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             flush_start;
    logic             walk_adv;
    logic             walk_last;
    logic [IDX_W-1:0] walk_idx;
    logic [WAY_W-1:0] walk_way;

    dcache_flush_walker #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) i_walker (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr_i),
        .start_i (flush_start),
        .adv_i   (walk_adv),
        .idx_o   (walk_idx),
        .way_o   (walk_way),
        .last_o  (walk_last)
    );

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        flush_start = 1'b0;
        walk_adv    = 1'b0;
        flush_ack_o = 1'b0;
        arr_req_o   = 1'b0;
        arr_we_o    = 1'b0;
        wb_req_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    flush_start = 1'b1;
                    state_d     = RD_TAG;
                end
            end
            RD_TAG: begin
                arr_req_o = 1'b1;
                if (arr_gnt_i) state_d = CHECK;
            end
            CHECK: begin
                if (arr_valid_i && arr_dirty_i) begin
                    tag_d   = arr_tag_i;
                    state_d = WB_REQ;
                end else begin
                    state_d = INVAL;
                end
            end
            WB_REQ: begin
                wb_req_o = 1'b1;
                // A write-back that completes in its grant cycle skips WB_WAIT.
                if (wb_gnt_i) state_d = wb_done_i ? INVAL : WB_WAIT;
            end
            WB_WAIT: begin
                if (wb_done_i) state_d = INVAL;
            end
            INVAL: begin
                arr_req_o = 1'b1;
                arr_we_o  = 1'b1;
                if (arr_gnt_i) begin
                    walk_adv = 1'b1;
                    state_d  = walk_last ? ACK : RD_TAG;
                end
            end
            ACK: begin
                flush_ack_o = 1'b1;
                state_d     = WAIT_LOW;
            end
            WAIT_LOW: begin
                // Absorbs the requester's late deassertion so it cannot re-trigger.
                if (!flush_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clr_i) begin
            state_d = IDLE;
            tag_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign arr_idx_o = walk_idx;
    assign arr_way_o = walk_way;
    assign wb_idx_o  = walk_idx;
    assign wb_way_o  = walk_way;
    assign wb_addr_o = {tag_q, walk_idx, {LINE_OFFSET{1'b0}}};

`ifdef DCACHE_FLUSH_STATS_EN
    logic [31:0] wb_count_q, wb_count_d;
    logic        wb_finish;

    assign wb_finish = ((state_q == WB_WAIT) && wb_done_i) ||
                       ((state_q == WB_REQ) && wb_gnt_i && wb_done_i);

    always_comb begin
        wb_count_d = wb_count_q;
        if (clr_i || flush_start) begin
            wb_count_d = '0;
        end else if (wb_finish && (wb_count_q != 32'hFFFF_FFFF)) begin
            wb_count_d = wb_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wb_count_q <= '0;
        else       wb_count_q <= wb_count_d;
    end

    assign wb_count_o = wb_count_q;
`else
    assign wb_count_o = '0;
`endif

endmodule

// File: doc/dcache_flush_unit.md
Name: dcache_flush_unit

Overview:
- Responder side of the data-cache flush handshake.
- Accepts a level flush request from the flush controller, walks every set/way of the write-back D-cache tag array, writes back dirty lines, invalidates all lines, then returns a one-cycle acknowledge.
- Sits inside the WB D-cache next to the miss handler and shares the tag-array port through an arbiter grant.

Parameters:
- NUM_SETS, 256, number of cache sets (power of two)
- NUM_WAYS, 8, associativity
- TAG_W, 44, tag width
- LINE_OFFSET, 4, log2 of line size in bytes
- ADDR_W, TAG_W+$clog2(NUM_SETS)+LINE_OFFSET, physical address width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- clr_i  in  1  synchronous clear; same effect as reset
- flush_i  in  1  flush request; held high until ack
- flush_ack_o  out  1  one-cycle pulse, flush complete
- busy_o  out  1  high in every state except IDLE
- arr_req_o  out  1  tag-array access request
- arr_gnt_i  in  1  tag-array grant from the arbiter
- arr_we_o  out  1  invalidate write (0 = read)
- arr_idx_o  out  $clog2(NUM_SETS)  set index
- arr_way_o  out  $clog2(NUM_WAYS)  way index
- arr_valid_i  in  1  line valid, 1 cycle after read grant
- arr_dirty_i  in  1  line dirty, 1 cycle after read grant
- arr_tag_i  in  TAG_W  line tag, 1 cycle after read grant
- wb_req_o  out  1  write-back request
- wb_addr_o  out  ADDR_W  {tag, index, LINE_OFFSET'b0}
- wb_idx_o / wb_way_o  out  as arr_*  data-array location to write back
- wb_gnt_i  in  1  write-back accepted
- wb_done_i  in  1  write-back finished (pulse)
- wb_count_o  out  32  dirty lines written back by last flush (see Optional Feature)

Behaviour:
- Reset / clr_i state: IDLE, index = 0, way = 0. All outputs 0.
- FSM states: IDLE, RD_TAG, CHECK, WB_REQ, WB_WAIT, INVAL, ACK, WAIT_LOW.
- IDLE: flush_i = 1 -> RD_TAG; clear the index/way counters and wb_count.
- RD_TAG:
  - arr_req_o = 1, arr_we_o = 0.
  - Hold until arr_gnt_i; on grant -> CHECK.
- CHECK (array data valid this cycle):
  - valid && dirty -> WB_REQ; latch tag.
  - Otherwise -> INVAL.
- WB_REQ:
  - wb_req_o = 1, with wb_addr_o, wb_idx_o and wb_way_o stable.
  - Hold until wb_gnt_i -> WB_WAIT.
  - If wb_gnt_i and wb_done_i arrive in the same cycle -> INVAL directly.
- WB_WAIT: wait for wb_done_i -> INVAL.
- INVAL:
  - arr_req_o = 1, arr_we_o = 1; write valid = 0, dirty = 0.
  - On arr_gnt_i, advance way.
  - On way wrap (NUM_WAYS-1 -> 0), advance index.
  - After set NUM_SETS-1 / way NUM_WAYS-1 -> ACK; else -> RD_TAG.
- ACK: flush_ack_o = 1 for exactly one cycle -> WAIT_LOW.
- WAIT_LOW:
  - Stay until flush_i = 0, then -> IDLE.
  - Prevents a re-trigger from the requester's one-cycle-late deassertion.
- Request drop: flush_i falling mid-walk is ignored; the walk always completes and acks.
- Counters: index and way are pure binary counters, wrapping modulo size; no extra state.
- Minimum latency with no dirty lines and constant grant: 3 cycles per line, so NUM_SETS*NUM_WAYS*3 + 1 cycles to ack.
- Reset or clr_i mid-walk:
  - Immediate return to IDLE; all outputs drop.
  - No ack is issued.
  - An outstanding write-back is abandoned; the requester is cleared by the same clr_i.
- busy_o is combinational from state; it blocks new misses in the cache controller.

Optional Feature:
- Macro: DCACHE_FLUSH_STATS_EN.
- Defined:
  - wb_count_o is a 32-bit saturating counter, incremented on each wb_done_i during a walk.
  - Cleared on flush start; held after ack until the next flush.
- Undefined: wb_count_o is tied to 0; no counter flops.

Decomposition:
- Shared package (ariane_pkg) holds:
  - the flush_state_e enum;
  - the DCACHE_SET_ASSOC / DCACHE_INDEX_WIDTH constants used for the defaults;
  - a flush_wb_req_t struct (addr, idx, way).
- One sub-module, dcache_flush_walker: the index/way counter pair with advance and last outputs.

Test Plan:
- Clean cache, NUM_SETS = 4, NUM_WAYS = 2, grant always 1, flush_i = 1 -> 8 invalidates, no wb_req_o, flush_ack_o pulses at cycle 25, wb_count_o = 0.
- Set 2 way 1 dirty with tag 0x5A -> exactly one wb_req_o with wb_addr_o = {0x5A, 2'd2, 4'b0}, held until wb_gnt_i; ack only after wb_done_i; wb_count_o = 1 with the stats macro, 0 without.
- arr_gnt_i low 5 cycles in RD_TAG and INVAL -> arr_idx_o / arr_way_o stable; no line skipped or repeated.
- flush_i kept high 3 cycles after ack -> no second walk; a new flush_i pulse after the drop starts a fresh walk from index 0.
- clr_i asserted while in WB_WAIT at set 1 -> IDLE next cycle, all outputs 0, no ack; a following flush restarts at set 0.
- Async rst_i asserted mid-cycle during INVAL -> outputs 0 immediately, without waiting for a clock edge.
